seq_divider: RTL and testbench

Multi-cycle unsigned 32-bit divider controller for the MIPS ALU. It sequences one instance of the team's 32-bit `subtractor` through a restoring-division algorithm, one quotient bit per clock. It sits beside the combinational ALU and serves DIVU-style operations through a start/done handshake. It is the only owner of its subtractor instance; no other requester shares it.

---
 rtl/seq_divider_if.sv | 24 ++
 rtl/seq_divider.sv | 124 ++++++++++++
 tb/tb_seq_divider.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/seq_divider_if.sv
// Start/done handshake and operand/result bundle between a requester and seq_divider.
// The requester drives the operands and start; the divider returns status and results.
interface seq_divider_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock through a single subtractor.
// Results and the divide-by-zero flag are registered and held until the next accepted start.
module seq_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_divider_if.slave  bus
);
    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  r_q, r_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic [WIDTH-1:0]  d_q, d_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  quo_q, quo_d;
    logic [WIDTH-1:0]  rem_q, rem_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              dbz_q, dbz_d;

    // Subtractor: T - D over 33 bits so the top bit is the borrow out.
    logic [WIDTH-1:0]  trial;
    logic [WIDTH:0]    sub;
    logic [WIDTH-1:0]  diff;
    logic              borrow;
    logic              take;
    logic [WIDTH-1:0]  r_next;
    logic [WIDTH-1:0]  q_next;

    assign trial  = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
    assign sub    = {1'b0, trial} - {1'b0, d_q};
    assign diff   = sub[WIDTH-1:0];
    assign borrow = sub[WIDTH];
    // A set R[31] means the 33-bit trial already exceeds D, so diff is exact.
    assign take   = r_q[WIDTH-1] | ~borrow;
    assign r_next = take ? diff : trial;
    assign q_next = {q_q[WIDTH-2:0], take};

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;

        unique case (state_q)
            // The done cycle doubles as an acceptance slot: one division every 33 cycles.
            StIdle, StDone: begin
                state_d = StIdle;
                if (bus.start) begin
                    if (bus.divisor != '0) begin
                        d_d     = bus.divisor;
                        q_d     = bus.dividend;
                        r_d     = '0;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                        dbz_d   = 1'b0;
                        state_d = StRun;
                    end else begin
                        quo_d   = '1;
                        rem_d   = bus.dividend;
                        dbz_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            StRun: begin
                r_d   = r_next;
                q_d   = q_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    quo_d   = q_next;
                    rem_d   = r_next;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: cycle-exact handshake timing and hand-computed results.
// All sampling happens 1 time unit after the rising edge.
module tb_seq_divider;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    seq_divider_if #(.WIDTH(32)) bus ();

    seq_divider #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full division with cycle-exact handshake checks; optionally scrambles inputs during RUN.
    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_q, input logic [31:0] exp_r,
                           input bit scramble);
        bit hs_ok;
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        step();  // E0
        bus.start = 1'b0;
        hs_ok = (bus.busy === 1'b1) && (bus.done === 1'b0);
        for (int k = 1; k < 32; k++) begin
            if (scramble) begin
                bus.dividend = $urandom;
                bus.divisor  = $urandom;
            end
            step();
            if (!((bus.busy === 1'b1) && (bus.done === 1'b0))) hs_ok = 1'b0;
        end
        chk({tag, " busy_run"}, {31'd0, hs_ok}, 32'd1);
        step();  // E32
        chk({tag, " done_e32"}, {31'd0, bus.done}, 32'd1);
        chk({tag, " busy_e32"}, {31'd0, bus.busy}, 32'd0);
        chk({tag, " quotient"}, bus.quotient, exp_q);
        chk({tag, " remainder"}, bus.remainder, exp_r);
        chk({tag, " dbz"}, {31'd0, bus.div_by_zero}, 32'd0);
        step();  // E33
        chk({tag, " done_e33"}, {31'd0, bus.done}, 32'd0);
    endtask

    initial begin
        bit seq_ok;
        bit seen_done;
        bit got;
        errors       = 0;
        checks       = 0;
        rst_n        = 1'b0;
        bus.start    = 1'b1;
        bus.dividend = 32'd77;
        bus.divisor  = 32'd0;
        step();
        step();
        chk("rst busy", {31'd0, bus.busy}, 32'd0);
        chk("rst done", {31'd0, bus.done}, 32'd0);
        chk("rst quotient", bus.quotient, 32'd0);
        chk("rst remainder", bus.remainder, 32'd0);
        chk("rst dbz", {31'd0, bus.div_by_zero}, 32'd0);
        bus.start = 1'b0;
        rst_n     = 1'b1;
        step();

        run_div("100/7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        run_div("80000000/3", 32'h8000_0000, 32'd3, 32'h2AAA_AAAA, 32'd2, 1'b0);
        run_div("ffffffff/80000001", 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 32'h7FFF_FFFE, 1'b0);
        run_div("3/10", 32'd3, 32'd10, 32'd0, 32'd3, 1'b0);
        run_div("ffffffff/1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);
        run_div("0/5", 32'd0, 32'd5, 32'd0, 32'd0, 1'b0);

        // Divide by zero: immediate result, no RUN.
        bus.start    = 1'b1;
        bus.dividend = 32'd1234;
        bus.divisor  = 32'd0;
        step();
        bus.start = 1'b0;
        chk("dbz done", {31'd0, bus.done}, 32'd1);
        chk("dbz busy", {31'd0, bus.busy}, 32'd0);
        chk("dbz quotient", bus.quotient, 32'hFFFF_FFFF);
        chk("dbz remainder", bus.remainder, 32'd1234);
        chk("dbz flag", {31'd0, bus.div_by_zero}, 32'd1);
        step();
        chk("dbz done_drop", {31'd0, bus.done}, 32'd0);
        chk("dbz busy_after", {31'd0, bus.busy}, 32'd0);
        run_div("9/3", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

        run_div("scrambled 123456789/1000", 32'd123456789, 32'd1000, 32'd123456, 32'd789, 1'b1);

        // Start held high: accepts at E0, E33, E66; done samples after E32 and E65.
        bus.start    = 1'b1;
        bus.dividend = 32'd50;
        bus.divisor  = 32'd5;
        seq_ok       = 1'b1;
        for (int k = 0; k <= 66; k++) begin
            step();
            if (bus.busy !== !(k == 32 || k == 65)) seq_ok = 1'b0;
            if (bus.done !== (k == 32 || k == 65)) seq_ok = 1'b0;
            if ((k == 32 || k == 65) && (bus.quotient !== 32'd10 || bus.remainder !== 32'd0))
                seq_ok = 1'b0;
        end
        chk("held start timing", {31'd0, seq_ok}, 32'd1);
        bus.start = 1'b0;
        got       = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            step();
            if (bus.done === 1'b1) got = 1'b1;
        end
        chk("held third done", {31'd0, got}, 32'd1);
        chk("held third quotient", bus.quotient, 32'd10);
        step();

        // Reset at E10 of an in-flight 1000/3.
        bus.start    = 1'b1;
        bus.dividend = 32'd1000;
        bus.divisor  = 32'd3;
        step();  // E0
        bus.start = 1'b0;
        for (int k = 1; k < 10; k++) step();
        rst_n = 1'b0;
        step();  // E10
        chk("midrst busy", {31'd0, bus.busy}, 32'd0);
        chk("midrst done", {31'd0, bus.done}, 32'd0);
        chk("midrst quotient", bus.quotient, 32'd0);
        chk("midrst remainder", bus.remainder, 32'd0);
        chk("midrst dbz", {31'd0, bus.div_by_zero}, 32'd0);
        rst_n     = 1'b1;
        seen_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (bus.done === 1'b1 || bus.busy === 1'b1) seen_done = 1'b1;
        end
        chk("midrst no_done", {31'd0, seen_done}, 32'd0);
        run_div("1000/3", 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
